// File: rtl/segway_uart_pkg.sv
// Shared types and constants for the Segway command-link UART receiver.
package segway_uart_pkg;

  localparam int BAUD_DIV_19200 = 2604;
  localparam int UART_DATA_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line; resets to the idle-high level.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
    end
  end

  assign o_sync = r_s2;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 command receiver: centre-sampled deframing, rdy/clr_rdy handshake,
// framing-error and overrun pulses.
module uart_cmd_rx
  import segway_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_19200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RX,
  input  logic                   clr_rdy,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rdy,
  output logic                   frm_err,
  output logic                   ovr
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(BAUD_DIV - 1);

  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [2:0]             r_bit_idx;
  logic [2:0]             w_idx_nxt;
  logic [UART_DATA_W-1:0] r_shift;
  logic [UART_DATA_W-1:0] r_rx_data;
  logic                   r_rdy;
  logic                   r_frm_err;
  logic                   r_ovr;
  logic                   w_rx_s;
  logic                   w_expire;
  logic                   w_shift_en;
  logic                   w_good;
  logic                   w_bad;

  rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (RX),
    .o_sync  (w_rx_s)
  );

  assign w_expire = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_bit_idx;
    w_shift_en  = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = HALF_LD;
        if (!w_rx_s) w_state_nxt = START;
      end
      START: begin
        if (w_expire) begin
          if (!w_rx_s) begin
            w_state_nxt = DATA;
            w_cnt_nxt   = FULL_LD;
            w_idx_nxt   = 3'd0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DATA: begin
        if (w_expire) begin
          w_shift_en = 1'b1;
          w_cnt_nxt  = FULL_LD;
          if (r_bit_idx == 3'd7) w_state_nxt = STOP;
          else                   w_idx_nxt   = r_bit_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      STOP: begin
        if (w_expire) begin
          w_good      = w_rx_s;
          w_bad       = !w_rx_s;
          // A low stop bit may be a break; wait for the line to recover
          // so the held-low level is not taken as a new start bit.
          w_state_nxt = w_rx_s ? IDLE : WAIT_HI;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      WAIT_HI: begin
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= '0;
      r_rx_data <= '0;
      r_rdy     <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_idx_nxt;
      if (w_shift_en) r_shift <= {w_rx_s, r_shift[UART_DATA_W-1:1]};
      r_frm_err <= w_bad;
      r_ovr     <= w_good & r_rdy;
      // Completion beats a simultaneous acknowledge so no byte is lost.
      if (w_good) begin
        r_rx_data <= r_shift;
        r_rdy     <= 1'b1;
      end else if (clr_rdy) begin
        r_rdy <= 1'b0;
      end
    end
  end

  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign frm_err = r_frm_err;
  assign ovr     = r_ovr;

endmodule
